add_op_arbiter: RTL and testbench
=================================

Name: add_op_arbiter

Overview:
- Shares one combinational AddOp adder instance among NUM_REQUESTERS independent requesters.
- Each requester issues operand pairs over a valid/ready channel. The arbiter grants one requester per cycle, round-robin.
- It registers the operands into an issue stage that drives the shared adder, then captures the sum into a response stage tagged with the requester index.
- It sits between ALU clients (e.g. address generation, counters) and the adder datapath.

Parameters:
- OPERAND_WIDTH, 32, width of lhs, rhs and result; must match the shared AddOp instance.
- NUM_REQUESTERS, 4, number of requester channels; must be >= 1.
- ID_WIDTH, max(1, $clog2(NUM_REQUESTERS)), width of the response tag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQUESTERS  per-requester operand pair valid.
- req_ready  output  NUM_REQUESTERS  per-requester accept; at most one bit set.
- req_lhs  input  NUM_REQUESTERS*OPERAND_WIDTH  packed lhs operands; requester i occupies bits [i*W +: W].
- req_rhs  input  NUM_REQUESTERS*OPERAND_WIDTH  packed rhs operands, same packing as req_lhs.
- add_lhs  output  OPERAND_WIDTH  to shared AddOp lhs.
- add_rhs  output  OPERAND_WIDTH  to shared AddOp rhs.
- add_result  input  OPERAND_WIDTH  from shared AddOp result; combinational function of add_lhs/add_rhs.
- resp_valid  output  1  response stage holds a result.
- resp_ready  input  1  consumer accepts the response.
- resp_result  output  OPERAND_WIDTH  sum.
- resp_id  output  ID_WIDTH  index of the requester that issued the pair.
- busy  output  1  issue stage or response stage occupied.

Behaviour:
- Reset (reset_n low, asynchronous): all of the following take their reset values immediately, regardless of clk.
  - Issue valid = 0 and response valid = 0.
  - RR pointer = 0.
  - Issue lhs/rhs/id = 0; response result/id = 0.
  - Outputs: resp_valid = 0, resp_result = 0, resp_id = 0, add_lhs = 0, add_rhs = 0, busy = 0.
  - req_ready = 0 while in reset.
  - Reset mid-operation discards in-flight operations with no response.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i] = 1, scanning from the pointer upward modulo NUM_REQUESTERS.
  - No grant when all req_valid are 0.
- Stage advancement:
  - resp_advance = !resp_valid_q || resp_ready.
  - issue_advance = issue_valid_q && resp_advance.
  - can_accept = !issue_valid_q || resp_advance.
  - req_ready[i] = grant[i] && can_accept.
  - req_ready depends combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Accept handshake (req_valid[i] && req_ready[i]):
  - Issue stage loads lhs_i, rhs_i and id = i, and sets issue valid.
  - Pointer becomes (i + 1) mod NUM_REQUESTERS.
  - Pointer is unchanged in cycles with no accept.
- Issue stage:
  - add_lhs/add_rhs are driven directly from the issue registers.
  - On issue_advance, the response stage captures add_result and the issue id, and sets response valid.
  - If there is no new accept in the same cycle, issue valid clears.
  - Accept and advance in the same cycle: the issue stage is overwritten with the new pair and stays valid.
- Response stage:
  - resp_valid, resp_result and resp_id are registered outputs, held stable while resp_valid && !resp_ready.
  - On resp_ready with no issue_advance, response valid clears.
- Idle data: data registers are not cleared when a stage drains. add_lhs/add_rhs keep the last issued operands.
- Latency: pair accepted at edge k gives resp_valid = 1 after edge k+1.
- Throughput: one operation per cycle with resp_ready held high.
- Backpressure: with resp_ready low, at most 2 operations are in flight. req_ready = 0 to all requesters once both stages are full.
- Arithmetic: the sum is modulo 2^OPERAND_WIDTH; carry-out is discarded by the adder and not reported.
- NUM_REQUESTERS = 1: pointer is constant 0, resp_id is always 0.
- busy = issue_valid_q || resp_valid_q.

Test Plan:
- Reset, then a single request: req_valid = 0001, lhs0 = 5, rhs0 = 7, resp_ready = 1.
  - req_ready = 0001 in the request cycle.
  - Two cycles later: resp_valid = 1, resp_result = 12, resp_id = 0.
  - busy falls after the response handshake.
- Round-robin fairness: all four requesters held valid, each with lhs = i, rhs = 100, resp_ready = 1.
  - Grants in order 0, 1, 2, 3, 0, ...
  - resp_id sequence 0, 1, 2, 3, 0, ...; results 100, 101, 102, 103.
  - One response per cycle after the 2-cycle fill.
- Backpressure: resp_ready = 0 with requesters 1 and 2 valid.
  - Two pairs accepted (ids 1, 2), then req_ready = 0000.
  - resp_result/resp_id held stable.
  - Raising resp_ready drains id 1 then id 2 on consecutive cycles; accepts resume in the same cycle the issue stage advances.
- Wrap-around: lhs = 0xFFFF_FFFF, rhs = 0x0000_0002 → resp_result = 0x0000_0001.
- Pointer skip: pointer = 2, only requester 0 valid → grant 0 and pointer becomes 1. Next, requesters 1 and 3 valid → grant 1.
- Asynchronous reset mid-operation: assert reset_n low between clock edges while both stages are full.
  - resp_valid, busy and add_lhs go to 0 immediately.
  - After release, the first grant goes to the lowest valid index ≥ 0.

Source files
------------

// File: rtl/add_op_arbiter.sv
// Round-robin arbiter sharing one combinational AddOp adder among several requesters.
// Operands go through an issue register, and the sum lands in a response register tagged with the requester id.
module add_op_arbiter #(
  parameter int OPERAND_WIDTH  = 32,
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_REQUESTERS-1:0]              req_valid,
  output logic [NUM_REQUESTERS-1:0]              req_ready,
  input  logic [NUM_REQUESTERS*OPERAND_WIDTH-1:0] req_lhs,
  input  logic [NUM_REQUESTERS*OPERAND_WIDTH-1:0] req_rhs,
  output logic [OPERAND_WIDTH-1:0]               add_lhs,
  output logic [OPERAND_WIDTH-1:0]               add_rhs,
  input  logic [OPERAND_WIDTH-1:0]               add_result,
  output logic                                   resp_valid,
  input  logic                                   resp_ready,
  output logic [OPERAND_WIDTH-1:0]               resp_result,
  output logic [ID_WIDTH-1:0]                    resp_id,
  output logic                                   busy
);

  logic                      issue_valid_q;
  logic [OPERAND_WIDTH-1:0]  issue_lhs_q;
  logic [OPERAND_WIDTH-1:0]  issue_rhs_q;
  logic [ID_WIDTH-1:0]       issue_id_q;
  logic                      resp_valid_q;
  logic [OPERAND_WIDTH-1:0]  resp_result_q;
  logic [ID_WIDTH-1:0]       resp_id_q;
  logic [ID_WIDTH-1:0]       rr_ptr_q;

  logic [NUM_REQUESTERS-1:0] grant;
  logic                      grant_found;
  logic [ID_WIDTH-1:0]       grant_id;
  logic [ID_WIDTH-1:0]       next_ptr;
  logic [OPERAND_WIDTH-1:0]  sel_lhs;
  logic [OPERAND_WIDTH-1:0]  sel_rhs;
  logic                      resp_advance;
  logic                      issue_advance;
  logic                      can_accept;
  logic                      accept;

  // Scan from the pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    next_ptr    = rr_ptr_q;
    sel_lhs     = '0;
    sel_rhs     = '0;
    for (int off = 0; off < NUM_REQUESTERS; off++) begin
      idx = (int'(rr_ptr_q) + off) % NUM_REQUESTERS;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_WIDTH'(idx);
        next_ptr    = (idx == NUM_REQUESTERS - 1) ? '0 : ID_WIDTH'(idx + 1);
        sel_lhs     = req_lhs[idx*OPERAND_WIDTH +: OPERAND_WIDTH];
        sel_rhs     = req_rhs[idx*OPERAND_WIDTH +: OPERAND_WIDTH];
      end
    end
  end

  assign resp_advance  = !resp_valid_q || resp_ready;
  assign issue_advance = issue_valid_q && resp_advance;
  assign can_accept    = !issue_valid_q || resp_advance;
  // Gated by reset_n so nothing looks accepted while the pipeline is held in reset.
  assign req_ready     = (reset_n && can_accept) ? grant : '0;
  assign accept        = grant_found && can_accept && reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_valid_q <= 1'b0;
      issue_lhs_q   <= '0;
      issue_rhs_q   <= '0;
      issue_id_q    <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= '0;
      rr_ptr_q      <= '0;
    end else begin
      if (accept) begin
        issue_lhs_q <= sel_lhs;
        issue_rhs_q <= sel_rhs;
        issue_id_q  <= grant_id;
        rr_ptr_q    <= next_ptr;
      end
      if (accept) begin
        issue_valid_q <= 1'b1;
      end else if (issue_advance) begin
        issue_valid_q <= 1'b0;
      end
      if (issue_advance) begin
        resp_valid_q  <= 1'b1;
        resp_result_q <= add_result;
        resp_id_q     <= issue_id_q;
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign add_lhs     = issue_lhs_q;
  assign add_rhs     = issue_rhs_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_id     = resp_id_q;
  assign busy        = issue_valid_q || resp_valid_q;

endmodule

// File: tb/tb_add_op_arbiter.sv
// Bench for add_op_arbiter: directed scenarios plus a randomized run against a queue-based reference model.
// The shared adder is modelled as a plain combinational sum.
module tb_add_op_arbiter;

  localparam int W = 32;
  localparam int N = 4;
  localparam int IDW = 2;

  logic             clk;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_lhs;
  logic [N*W-1:0]   req_rhs;
  logic [W-1:0]     add_lhs;
  logic [W-1:0]     add_rhs;
  logic [W-1:0]     add_result;
  logic             resp_valid;
  logic             resp_ready;
  logic [W-1:0]     resp_result;
  logic [IDW-1:0]   resp_id;
  logic             busy;

  int errors;
  int checks;

  add_op_arbiter #(.OPERAND_WIDTH(W), .NUM_REQUESTERS(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .add_lhs    (add_lhs),
    .add_rhs    (add_rhs),
    .add_result (add_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  assign add_result = add_lhs + add_rhs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ops(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
    req_lhs[i*W +: W] = l;
    req_rhs[i*W +: W] = r;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, W'(i + 1), W'(9));
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready got=%b want=0000", req_ready); end
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_busy got=%b/%b want=0/0", resp_valid, busy); end
    checks++;
    if (add_lhs !== '0 || add_rhs !== '0) begin errors++; $display("[TB] FAIL reset_add_ops got=%h/%h want=0/0", add_lhs, add_rhs); end
    checks++;
    if (resp_result !== '0 || resp_id !== '0) begin errors++; $display("[TB] FAIL reset_resp got=%h/%0d want=0/0", resp_result, resp_id); end
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_ops(0, 32'd5, 32'd7);
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_req_ready got=%b want=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b1 || resp_valid !== 1'b0 || add_lhs !== 32'd5) begin
      errors++; $display("[TB] FAIL single_issue got busy=%b rv=%b lhs=%0d want 1/0/5", busy, resp_valid, add_lhs);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 32'd12 || resp_id !== 2'd0) begin
      errors++; $display("[TB] FAIL single_resp got rv=%b res=%0d id=%0d want 1/12/0", resp_valid, resp_result, resp_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || add_lhs !== 32'd5) begin
      errors++; $display("[TB] FAIL single_drain got busy=%b rv=%b lhs=%0d want 0/0/5", busy, resp_valid, add_lhs);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, W'(i), W'(100));
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (c % N))) begin
        errors++; $display("[TB] FAIL rr_grant cycle=%0d got=%b want=%b", c, req_ready, 4'(1 << (c % N)));
      end
      if (c >= 2) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== IDW'((c - 2) % N) || resp_result !== W'(100 + (c - 2) % N)) begin
          errors++; $display("[TB] FAIL rr_resp cycle=%0d got rv=%b id=%0d res=%0d want 1/%0d/%0d",
                             c, resp_valid, resp_id, resp_result, (c - 2) % N, 100 + (c - 2) % N);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ops(1, 32'd10, 32'd1);
    set_ops(2, 32'd20, 32'd1);
    req_valid  = 4'b0110;
    resp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_first got=%b want=0010", req_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL bp_second got=%b want=0100", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 32'd11) begin
        errors++; $display("[TB] FAIL bp_hold cycle=%0d got rdy=%b rv=%b id=%0d res=%0d want 0000/1/1/11",
                           c, req_ready, resp_valid, resp_id, resp_result);
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_resume got=%b want=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_result !== 32'd21) begin
      errors++; $display("[TB] FAIL bp_drain2 got rv=%b id=%0d res=%0d want 1/2/21", resp_valid, resp_id, resp_result);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 32'd11) begin
      errors++; $display("[TB] FAIL bp_drain3 got rv=%b id=%0d res=%0d want 1/1/11", resp_valid, resp_id, resp_result);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_idle got rv=%b busy=%b want 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_ops(2, 32'hFFFF_FFFF, 32'h0000_0002);
    req_valid  = 4'b0100;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== 32'h0000_0001 || resp_id !== 2'd2) begin
      errors++; $display("[TB] FAIL wrap got rv=%b res=%h id=%0d want 1/00000001/2", resp_valid, resp_result, resp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_pointer_skip();
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, W'(i), W'(1));
    resp_ready = 1'b1;
    req_valid  = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL skip_grant0 got=%b want=0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL skip_grant1 got=%b want=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_ops(0, 32'd3, 32'd1);
    set_ops(1, 32'd4, 32'd1);
    resp_ready = 1'b0;
    req_valid  = 4'b0011;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || resp_valid !== 1'b1 || add_lhs !== 32'd4 || req_ready !== 4'b0000) begin
      errors++; $display("[TB] FAIL areset_full got busy=%b rv=%b lhs=%0d rdy=%b want 1/1/4/0000",
                         busy, resp_valid, add_lhs, req_ready);
    end
    #1;
    reset_n   = 1'b0;
    req_valid = 4'b0110;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || add_lhs !== '0 || req_ready !== 4'b0000) begin
      errors++; $display("[TB] FAIL areset_clear got rv=%b busy=%b lhs=%0d rdy=%b want 0/0/0/0000",
                         resp_valid, busy, add_lhs, req_ready);
    end
    @(negedge clk);
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL areset_first_grant got=%b want=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] sum;
    int           id;
    bit           in_resp;
  } op_t;

  // Randomized traffic against a model: a queue of in-flight ops holding at most two entries,
  // where the front entry becomes visible one edge after acceptance.
  task automatic test_random();
    op_t          q[$];
    op_t          e;
    int           mptr;
    int           gid;
    bit           can;
    bit           exp_rv;
    logic [N-1:0] exp_rr;
    logic [W-1:0] mlhs;
    logic [W-1:0] mrhs;
    do_reset();
    mptr = 0;
    mlhs = '0;
    mrhs = '0;
    for (int c = 0; c < 400; c++) begin
      req_valid  = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
      exp_rv = (q.size() > 0) && q[0].in_resp;
      can    = (q.size() < 2) || resp_ready;
      gid    = -1;
      for (int off = 0; off < N; off++) begin
        if (gid < 0 && req_valid[(mptr + off) % N]) gid = (mptr + off) % N;
      end
      exp_rr = (gid >= 0 && can) ? 4'(1 << gid) : 4'b0000;
      #1;
      checks++;
      if (req_ready !== exp_rr) begin errors++; $display("[TB] FAIL rnd_ready cycle=%0d got=%b want=%b", c, req_ready, exp_rr); end
      checks++;
      if (resp_valid !== exp_rv || busy !== (q.size() > 0)) begin
        errors++; $display("[TB] FAIL rnd_valid cycle=%0d got rv=%b busy=%b want %b/%b", c, resp_valid, busy, exp_rv, q.size() > 0);
      end
      checks++;
      if (add_lhs !== mlhs || add_rhs !== mrhs) begin
        errors++; $display("[TB] FAIL rnd_addops cycle=%0d got=%h/%h want=%h/%h", c, add_lhs, add_rhs, mlhs, mrhs);
      end
      if (exp_rv) begin
        checks++;
        if (resp_result !== q[0].sum || resp_id !== IDW'(q[0].id)) begin
          errors++; $display("[TB] FAIL rnd_resp cycle=%0d got res=%h id=%0d want %h/%0d", c, resp_result, resp_id, q[0].sum, q[0].id);
        end
      end
      @(posedge clk);
      if (exp_rv && resp_ready) void'(q.pop_front());
      if (q.size() > 0) q[0].in_resp = 1'b1;
      if (exp_rr != 0) begin
        mlhs      = req_lhs[gid*W +: W];
        mrhs      = req_rhs[gid*W +: W];
        e.sum     = mlhs + mrhs;
        e.id      = gid;
        e.in_resp = 1'b0;
        q.push_back(e);
        mptr = (gid + 1) % N;
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset_n    = 1'b0;
    req_valid  = '0;
    req_lhs    = '0;
    req_rhs    = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_pointer_skip();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
